// File: rtl/peak_window_ctrl_if.sv
// peak_window_ctrl_if: sample stream into the window-peak sequencer.
// The source side drives IN_VALID/IN_DATA and watches IN_READY.
// The sequencer side reads IN_VALID/IN_DATA and drives IN_READY.
// A sample moves on any rising edge where IN_VALID and IN_READY are both high.
interface peak_window_ctrl_if #(
    parameter int DATA_W = 12
);
    logic              IN_VALID;
    logic              IN_READY;
    logic [DATA_W-1:0] IN_DATA;

    modport master (
        output IN_VALID,
        output IN_DATA,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID,
        input  IN_DATA,
        output IN_READY
    );
endinterface

// File: rtl/peak_window_ctrl.sv
// peak_window_ctrl: tracks the largest unsigned sample in a window of WINDOW
// accepted samples and reports it. The running max uses a compare/select
// feedback register. START opens a window. ABORT cancels a window in progress.
// A one-cycle PEAK_VALID pulse announces each completed window.
//
// Optional build feature, enabled with `define PEAK_WINDOW_INDEX_EN:
// it adds the PEAK_IDX output. PEAK_IDX is the zero-based position, within
// the window, of the sample that produced PEAK_OUT. Ties report the earliest
// position.
//
// IN_READY, BUSY and PEAK_VALID are registered copies of the next state.
// Downstream logic therefore sees clean flop outputs.
module peak_window_ctrl #(
    parameter int DATA_W = 12,
    parameter int WINDOW = 256,
    parameter int CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    input  logic                 ABORT,
    peak_window_ctrl_if.slave    in_bus,
    output logic                 BUSY,
    output logic                 PEAK_VALID,
    output logic [DATA_W-1:0]    PEAK_OUT
`ifdef PEAK_WINDOW_INDEX_EN
    ,
    output logic [CNT_W-1:0]     PEAK_IDX
`endif
);

    // Counter value held while the last sample of a window is being accepted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] max_q;
    logic [DATA_W-1:0] max_d;
    logic              first_q;
    logic              first_d;
    logic [DATA_W-1:0] peak_q;
    logic [DATA_W-1:0] peak_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              busy_q;
    logic              busy_d;
    logic              peak_valid_q;
    logic              peak_valid_d;

    logic              accept;
    logic              take;
    logic [DATA_W-1:0] cand_max;

`ifdef PEAK_WINDOW_INDEX_EN
    logic [CNT_W-1:0]  max_idx_q;
    logic [CNT_W-1:0]  max_idx_d;
    logic [CNT_W-1:0]  peak_idx_q;
    logic [CNT_W-1:0]  peak_idx_d;
    logic [CNT_W-1:0]  cand_idx;
`endif

    // Register the state, the datapath and the outputs. RST takes priority over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            max_q        <= '0;
            first_q      <= 1'b0;
            peak_q       <= '0;
            in_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            peak_valid_q <= 1'b0;
`ifdef PEAK_WINDOW_INDEX_EN
            max_idx_q    <= '0;
            peak_idx_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            max_q        <= max_d;
            first_q      <= first_d;
            peak_q       <= peak_d;
            in_ready_q   <= in_ready_d;
            busy_q       <= busy_d;
            peak_valid_q <= peak_valid_d;
`ifdef PEAK_WINDOW_INDEX_EN
            max_idx_q    <= max_idx_d;
            peak_idx_q   <= peak_idx_d;
`endif
        end
    end

    // Next-state logic: window sequencing, running-max compare/select, and the registered output values.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        first_d  = first_q;
        peak_d   = peak_q;
`ifdef PEAK_WINDOW_INDEX_EN
        max_idx_d  = max_idx_q;
        peak_idx_d = peak_idx_q;
`endif

        // ABORT wins over a sample offered in the same cycle.
        accept = (state_q == RUN) && in_ready_q && in_bus.IN_VALID && !ABORT;

        // The first sample always loads. After that, a strictly greater sample replaces the max, so ties keep the earlier value.
        take     = first_q || (in_bus.IN_DATA > max_q);
        cand_max = take ? in_bus.IN_DATA : max_q;
`ifdef PEAK_WINDOW_INDEX_EN
        cand_idx = take ? cnt_q : max_idx_q;
`endif

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end
            end

            RUN: begin
                if (ABORT) begin
                    state_d = IDLE;
                end else if (accept) begin
                    max_d   = cand_max;
                    first_d = 1'b0;
`ifdef PEAK_WINDOW_INDEX_EN
                    max_idx_d = cand_idx;
`endif
                    if (cnt_q == LAST_CNT) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        peak_d  = cand_max;
`ifdef PEAK_WINDOW_INDEX_EN
                        peak_idx_d = cand_idx;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            DONE: begin
                if (START) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    first_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d   = (state_d == RUN);
        busy_d       = (state_d == RUN);
        peak_valid_d = (state_d == DONE);
    end

    assign in_bus.IN_READY = in_ready_q;
    assign BUSY            = busy_q;
    assign PEAK_VALID      = peak_valid_q;
    assign PEAK_OUT        = peak_q;
`ifdef PEAK_WINDOW_INDEX_EN
    assign PEAK_IDX        = peak_idx_q;
`endif

endmodule

// File: tb/tb_peak_window_ctrl.sv
// tb_peak_window_ctrl: scoreboard bench for peak_window_ctrl.
// The main instance uses WINDOW=4. A second instance uses WINDOW=1 to cover
// the single-sample window. Expected peaks are computed from each window's
// samples when the window is driven. They are popped when PEAK_VALID pulses.
module tb_peak_window_ctrl;

    localparam int DATA_W = 12;
    localparam int WINDOW = 4;
    localparam int CNT_W  = 2;

    typedef logic [3:0][DATA_W-1:0] window_t;
    typedef struct {
        logic [DATA_W-1:0] peak;
        int                idx;
    } sb_entry_t;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic              abort;
    logic              busy;
    logic              peak_valid;
    logic [DATA_W-1:0] peak_out;
    logic              start1;
    logic              abort1;
    logic              busy1;
    logic              peak_valid1;
    logic [DATA_W-1:0] peak_out1;
`ifdef PEAK_WINDOW_INDEX_EN
    logic [CNT_W-1:0]  peak_idx;
    logic [0:0]        peak_idx1;
`endif

    int        check_count = 0;
    int        fail_count  = 0;
    int        busy_cycles = 0;
    sb_entry_t sb_q[$];
    sb_entry_t sb1_q[$];
    sb_entry_t sb_head;
    sb_entry_t sb1_head;

    peak_window_ctrl_if #(.DATA_W(DATA_W)) bus  ();
    peak_window_ctrl_if #(.DATA_W(DATA_W)) bus1 ();

    peak_window_ctrl #(.DATA_W(DATA_W), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .START      (start),
        .ABORT      (abort),
        .in_bus     (bus),
        .BUSY       (busy),
        .PEAK_VALID (peak_valid),
        .PEAK_OUT   (peak_out)
`ifdef PEAK_WINDOW_INDEX_EN
        ,
        .PEAK_IDX   (peak_idx)
`endif
    );

    peak_window_ctrl #(.DATA_W(DATA_W), .WINDOW(1), .CNT_W(1)) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .START      (start1),
        .ABORT      (abort1),
        .in_bus     (bus1),
        .BUSY       (busy1),
        .PEAK_VALID (peak_valid1),
        .PEAK_OUT   (peak_out1)
`ifdef PEAK_WINDOW_INDEX_EN
        ,
        .PEAK_IDX   (peak_idx1)
`endif
    );

    // Free-running clock for both instances.
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic window_t mkWindow(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                         input logic [DATA_W-1:0] c, input logic [DATA_W-1:0] d);
        window_t w;
        w[0] = a;
        w[1] = b;
        w[2] = c;
        w[3] = d;
        return w;
    endfunction

    // Reference model: the first sample loads, a strictly greater one replaces it, and ties keep the earliest.
    task automatic pushExpected(input window_t w);
        sb_entry_t e;
        e.peak = w[0];
        e.idx  = 0;
        for (int i = 1; i < 4; i++) begin
            if (w[i] > e.peak) begin
                e.peak = w[i];
                e.idx  = i;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] data, input int gap);
        int waited;
        bus.IN_VALID = 1'b0;
        repeat (gap) tick();
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = data;
        waited = 0;
        while (!bus.IN_READY && waited < 16) begin
            tick();
            waited++;
        end
        if (!bus.IN_READY) checkOutput("accept_timeout", 32'(bus.IN_READY), 32'd1);
        tick();
    endtask

    task automatic startWindow();
        bus.IN_VALID = 1'b0;
        start        = 1'b1;
        busy_cycles  = 0;
        tick();
        start        = 1'b0;
    endtask

    task automatic feedWindow(input window_t w, input int gap, input bit hold_start);
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                pushExpected(w);
                if (hold_start) start = 1'b1;
            end
            applyStimulus(w[i], gap);
        end
        bus.IN_VALID = 1'b0;
    endtask

    // Scoreboard pop for the WINDOW=4 instance. Also counts the cycles that BUSY is high.
    always @(negedge CLK) begin
        if (!RST && peak_valid) begin
            if (sb_q.size() == 0) begin
                checkOutput("unexpected_peak_valid", 32'(peak_valid), 32'd0);
            end else begin
                sb_head = sb_q.pop_front();
                checkOutput("sb_peak", 32'(peak_out), 32'(sb_head.peak));
`ifdef PEAK_WINDOW_INDEX_EN
                checkOutput("sb_idx", 32'(peak_idx), sb_head.idx);
`endif
            end
        end
        if (!RST && busy) busy_cycles++;
    end

    // Scoreboard pop for the WINDOW=1 instance.
    always @(negedge CLK) begin
        if (!RST && peak_valid1) begin
            if (sb1_q.size() == 0) begin
                checkOutput("unexpected_peak_valid1", 32'(peak_valid1), 32'd0);
            end else begin
                sb1_head = sb1_q.pop_front();
                checkOutput("sb1_peak", 32'(peak_out1), 32'(sb1_head.peak));
`ifdef PEAK_WINDOW_INDEX_EN
                checkOutput("sb1_idx", 32'(peak_idx1), sb1_head.idx);
`endif
            end
        end
    end

    // Watchdog so a stuck run still ends.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main stimulus sequence.
    initial begin
        sb_entry_t e1;
        RST           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        start1        = 1'b0;
        abort1        = 1'b0;
        bus.IN_VALID  = 1'b0;
        bus.IN_DATA   = '0;
        bus1.IN_VALID = 1'b0;
        bus1.IN_DATA  = '0;

        tick();
        tick();
        RST = 1'b0;
        repeat (5) tick();
        checkOutput("reset_peak_out", 32'(peak_out), 32'd0);
        checkOutput("reset_peak_valid", 32'(peak_valid), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_in_ready", 32'(bus.IN_READY), 32'd0);
`ifdef PEAK_WINDOW_INDEX_EN
        checkOutput("reset_peak_idx", 32'(peak_idx), 32'd0);
`endif

        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = 12'd321;
        repeat (3) tick();
        checkOutput("idle_in_ready", 32'(bus.IN_READY), 32'd0);
        checkOutput("idle_busy", 32'(busy), 32'd0);
        bus.IN_VALID = 1'b0;

        startWindow();
        checkOutput("run_in_ready", 32'(bus.IN_READY), 32'd1);
        checkOutput("run_busy", 32'(busy), 32'd1);
        feedWindow(mkWindow(12'd5, 12'd900, 12'd900, 12'd3), 0, 1'b0);
        checkOutput("nom_valid", 32'(peak_valid), 32'd1);
        checkOutput("nom_peak", 32'(peak_out), 32'd900);
`ifdef PEAK_WINDOW_INDEX_EN
        checkOutput("nom_idx", 32'(peak_idx), 32'd1);
`endif
        checkOutput("nom_busy_cycles", 32'(busy_cycles), 32'd4);
        checkOutput("nom_done_ready", 32'(bus.IN_READY), 32'd0);
        tick();
        checkOutput("nom_pulse_width", 32'(peak_valid), 32'd0);
        checkOutput("nom_hold", 32'(peak_out), 32'd900);
        checkOutput("nom_idle_busy", 32'(busy), 32'd0);

        startWindow();
        feedWindow(mkWindow(12'd0, 12'd4095, 12'd0, 12'd0), 3, 1'b0);
        checkOutput("gap_valid", 32'(peak_valid), 32'd1);
        checkOutput("gap_peak", 32'(peak_out), 32'd4095);
        checkOutput("gap_busy_cycles", 32'(busy_cycles), 32'd16);
        tick();

        startWindow();
        applyStimulus(12'd77, 0);
        applyStimulus(12'd88, 0);
        bus.IN_DATA  = 12'd99;
        bus.IN_VALID = 1'b1;
        abort        = 1'b1;
        tick();
        abort        = 1'b0;
        bus.IN_VALID = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_in_ready", 32'(bus.IN_READY), 32'd0);
        checkOutput("abort_valid", 32'(peak_valid), 32'd0);
        checkOutput("abort_peak_hold", 32'(peak_out), 32'd4095);
        repeat (3) tick();
        checkOutput("abort_peak_later", 32'(peak_out), 32'd4095);
`ifdef PEAK_WINDOW_INDEX_EN
        checkOutput("abort_idx_hold", 32'(peak_idx), 32'd1);
`endif

        startWindow();
        feedWindow(mkWindow(12'd1, 12'd2, 12'd3, 12'd4), 0, 1'b1);
        checkOutput("b2b1_valid", 32'(peak_valid), 32'd1);
        checkOutput("b2b1_peak", 32'(peak_out), 32'd4);
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        checkOutput("b2b_rerun_busy", 32'(busy), 32'd1);
        checkOutput("b2b_rerun_ready", 32'(bus.IN_READY), 32'd1);
        checkOutput("b2b_rerun_valid", 32'(peak_valid), 32'd0);
        checkOutput("b2b_first_hold", 32'(peak_out), 32'd4);
        feedWindow(mkWindow(12'd10, 12'd20, 12'd30, 12'd40), 0, 1'b0);
        checkOutput("b2b2_valid", 32'(peak_valid), 32'd1);
        checkOutput("b2b2_peak", 32'(peak_out), 32'd40);
        tick();

        startWindow();
        applyStimulus(12'd50, 0);
        bus.IN_VALID = 1'b0;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        applyStimulus(12'd60, 0);
        applyStimulus(12'd70, 0);
        pushExpected(mkWindow(12'd50, 12'd60, 12'd70, 12'd80));
        applyStimulus(12'd80, 0);
        bus.IN_VALID = 1'b0;
        checkOutput("start_in_run_valid", 32'(peak_valid), 32'd1);
        checkOutput("start_in_run_peak", 32'(peak_out), 32'd80);
        tick();

        startWindow();
        applyStimulus(12'd77, 0);
        applyStimulus(12'd88, 0);
        bus.IN_VALID = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checkOutput("rst_mid_peak", 32'(peak_out), 32'd0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_ready", 32'(bus.IN_READY), 32'd0);
        repeat (2) tick();
        checkOutput("rst_mid_valid", 32'(peak_valid), 32'd0);

        startWindow();
        feedWindow(mkWindow(12'd0, 12'd0, 12'd0, 12'd0), 0, 1'b0);
        checkOutput("zero_valid", 32'(peak_valid), 32'd1);
        checkOutput("zero_peak", 32'(peak_out), 32'd0);
        tick();
        checkOutput("zero_pulse_width", 32'(peak_valid), 32'd0);

        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        checkOutput("w1_in_ready", 32'(bus1.IN_READY), 32'd1);
        bus1.IN_VALID = 1'b1;
        bus1.IN_DATA  = 12'd1234;
        e1.peak = 12'd1234;
        e1.idx  = 0;
        sb1_q.push_back(e1);
        tick();
        bus1.IN_VALID = 1'b0;
        checkOutput("w1_valid", 32'(peak_valid1), 32'd1);
        checkOutput("w1_peak", 32'(peak_out1), 32'd1234);
        tick();
        checkOutput("w1_pulse_width", 32'(peak_valid1), 32'd0);
        checkOutput("w1_hold", 32'(peak_out1), 32'd1234);

        repeat (2) tick();
        checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);
        checkOutput("sb1_drain", 32'(sb1_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
